// File: rtl/scale_2d_sched.sv
// Vertical line scheduler for a 2-D scaler: walks source lines with a Bresenham
// accumulator and launches one horizontal-scaler pass per output line.
module scale_2d_sched #(
  parameter int C_S_HEIGHT_WIDTH = 12,
  parameter int C_M_HEIGHT_WIDTH = 12,
  parameter int C_S_ADDR_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        fsync,
  input  logic [C_S_HEIGHT_WIDTH-1:0] s_height,
  input  logic [C_M_HEIGHT_WIDTH-1:0] m_height,
  input  logic [C_S_ADDR_WIDTH-1:0]   s_base_addr,
  input  logic [C_S_ADDR_WIDTH-1:0]   s_stride,
  output logic                        line_start,
  output logic [C_S_ADDR_WIDTH-1:0]   line_addr,
  output logic [C_S_HEIGHT_WIDTH-1:0] s_row,
  output logic [C_M_HEIGHT_WIDTH-1:0] m_row,
  input  logic                        line_done,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        fsync_drop
);

  localparam int SW = C_S_HEIGHT_WIDTH;
  localparam int MW = C_M_HEIGHT_WIDTH;
  localparam int CW = SW + MW;

  typedef enum logic [2:0] {IDLE, SEEK, ISSUE, WAIT, DONE} state_t;

  state_t                    state;
  logic [SW-1:0]             s_h_r;
  logic [MW-1:0]             m_h_r;
  logic [C_S_ADDR_WIDTH-1:0] stride_r;
  logic [CW-1:0]             s_cnt, m_cnt;
  logic [CW-1:0]             s_h_ext, m_h_ext;

  assign s_h_ext    = {{MW{1'b0}}, s_h_r};
  assign m_h_ext    = {{SW{1'b0}}, m_h_r};
  assign fsync_drop = fsync && (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      s_h_r      <= '0;
      m_h_r      <= '0;
      stride_r   <= '0;
      s_cnt      <= '0;
      m_cnt      <= '0;
      line_addr  <= '0;
      s_row      <= '0;
      m_row      <= '0;
      line_start <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      line_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (fsync) begin
          s_h_r     <= s_height;
          m_h_r     <= m_height;
          stride_r  <= s_stride;
          s_cnt     <= {{SW{1'b0}}, m_height};
          m_cnt     <= {{MW{1'b0}}, s_height};
          s_row     <= '0;
          m_row     <= '0;
          line_addr <= s_base_addr;
          busy      <= 1'b1;
          state     <= (s_height == '0 || m_height == '0) ? DONE : SEEK;
        end
        // Accumulators compare (s_row+1)*m_height against (m_row+1)*s_height.
        SEEK: if (s_cnt < m_cnt) begin
          s_cnt     <= s_cnt + m_h_ext;
          s_row     <= s_row + SW'(1);
          line_addr <= line_addr + stride_r;
        end else begin
          line_start <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (line_done) begin
          if (s_cnt <= m_cnt) begin
            s_cnt     <= s_cnt + m_h_ext;
            s_row     <= s_row + SW'(1);
            line_addr <= line_addr + stride_r;
          end
          m_cnt <= m_cnt + s_h_ext;
          if (m_row == m_h_r - MW'(1)) begin
            state <= DONE;
          end else begin
            m_row <= m_row + MW'(1);
            state <= SEEK;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
